// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit holding the HI/LO registers.
// Results are computed combinationally when an op is accepted, parked in
// tmp registers, and committed to HI/LO when the latency counter expires.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CW-1:0] MULT_N  = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N   = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  // State flops
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   tmp_hi_q, tmp_hi_d;
  logic [31:0]   tmp_lo_q, tmp_lo_d;
  logic          commit_q, commit_d;

  // Datapath intermediates
  logic          is_md_op_s;
  logic [63:0]   a_sx_s, b_sx_s, prod_s_s, prod_u_s;
  logic [31:0]   a_mag_s, b_mag_s, div_mag_s, div_u_s;
  logic [31:0]   q_mag_s, r_mag_s, q_sgn_s, r_sgn_s;
  logic [31:0]   q_u_s, r_u_s;
  logic [31:0]   res_hi_s, res_lo_s;
  logic          res_wr_s;
  logic [CW-1:0] res_n_s;

  // Decode which ops occupy the unit for multiple cycles
  always_comb begin
    case (MDOp)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_md_op_s = 1'b1;
      default:                            is_md_op_s = 1'b0;
    endcase
  end

  assign Start = is_md_op_s & ~busy_q;

  // Multiply and divide arithmetic on the live operands
  always_comb begin
    a_sx_s   = {{32{A[31]}}, A};
    b_sx_s   = {{32{B[31]}}, B};
    prod_s_s = a_sx_s * b_sx_s;
    prod_u_s = {32'h0000_0000, A} * {32'h0000_0000, B};

    // Signed divide through magnitudes so -2^31 / -1 wraps to 0x80000000
    a_mag_s   = A[31] ? (~A + 32'd1) : A;
    b_mag_s   = B[31] ? (~B + 32'd1) : B;
    // Divisor of zero is replaced by one; the result is discarded anyway
    div_mag_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
    div_u_s   = (B == 32'd0) ? 32'd1 : B;
    q_mag_s   = a_mag_s / div_mag_s;
    r_mag_s   = a_mag_s % div_mag_s;
    q_sgn_s   = (A[31] ^ B[31]) ? (~q_mag_s + 32'd1) : q_mag_s;
    r_sgn_s   = A[31] ? (~r_mag_s + 32'd1) : r_mag_s;
    q_u_s     = A / div_u_s;
    r_u_s     = A % div_u_s;
  end

  // Select the pending result, its latency and whether it will commit
  always_comb begin
    res_hi_s = 32'd0;
    res_lo_s = 32'd0;
    res_wr_s = 1'b0;
    res_n_s  = CNT_ZERO;
    case (MDOp)
      OP_MULT: begin
        res_hi_s = prod_s_s[63:32];
        res_lo_s = prod_s_s[31:0];
        res_wr_s = 1'b1;
        res_n_s  = MULT_N;
      end
      OP_MULTU: begin
        res_hi_s = prod_u_s[63:32];
        res_lo_s = prod_u_s[31:0];
        res_wr_s = 1'b1;
        res_n_s  = MULT_N;
      end
      OP_DIV: begin
        res_hi_s = r_sgn_s;
        res_lo_s = q_sgn_s;
        res_wr_s = (B != 32'd0);
        res_n_s  = DIV_N;
      end
      OP_DIVU: begin
        res_hi_s = r_u_s;
        res_lo_s = q_u_s;
        res_wr_s = (B != 32'd0);
        res_n_s  = DIV_N;
      end
      default: begin
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        res_wr_s = 1'b0;
        res_n_s  = CNT_ZERO;
      end
    endcase
  end

  // IDLE/RUN sequencing: accept ops, count down, commit on expiry, mthi/mtlo
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    commit_d = commit_q;
    if (busy_q) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        busy_d = 1'b0;
        if (commit_q) begin
          hi_d = tmp_hi_q;
          lo_d = tmp_lo_q;
        end else begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      if (is_md_op_s) begin
        busy_d   = 1'b1;
        cnt_d    = res_n_s;
        tmp_hi_d = res_hi_s;
        tmp_lo_d = res_lo_s;
        commit_d = res_wr_s;
      end else if (MDOp == OP_MTHI) begin
        hi_d = A;
      end else if (MDOp == OP_MTLO) begin
        lo_d = A;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  // State registers; reset drops any pending result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= CNT_ZERO;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      commit_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      commit_q <= commit_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

  // OP_NONE is decoded implicitly through the default arms above
  localparam logic [2:0] OP_NONE_UNUSED = OP_NONE;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit with hand-computed expected values.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_fails  = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: drop op after Start; 1: hold op and operands;
  // 2: drive div with zero operands during RUN
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int mode, input int exp_n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    MDOp = op; A = a; B = b;
    #1;
    check({tag, "_start"}, {31'd0, Start}, 32'd1);
    tick();
    check({tag, "_busy_rise"}, {31'd0, Busy}, 32'd1);
    case (mode)
      1: begin MDOp = op; end
      2: begin MDOp = 3'd3; A = 32'd0; B = 32'd0; end
      default: begin MDOp = 3'd0; end
    endcase
    if (mode != 0) begin
      #1;
      check({tag, "_start_suppressed"}, {31'd0, Start}, 32'd0);
    end
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    MDOp = 3'd0;
    check({tag, "_busy_cycles"}, n, exp_n);
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
  endtask

  // Global guard so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Directed stimulus sequence
  initial begin
    int n;
    reset = 1'b1; MDOp = 3'd0; A = 32'd0; B = 32'd0;
    #7;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_start", {31'd0, Start}, 32'd0);
    #5 reset = 1'b0;
    tick();

    // mult -3 * 5, op held during RUN to check Start suppression
    run_op("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd5, 1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    // multu then back-to-back signed div
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 0, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // preset HI/LO, then divide by zero leaves them untouched
    MDOp = 3'd5; A = 32'h11;
    tick();
    check("mthi_11", HI, 32'h11);
    MDOp = 3'd6; A = 32'h22;
    tick();
    check("mtlo_22", LO, 32'h22);
    check("mtlo_hi_kept", HI, 32'h11);
    run_op("divu_zero", 3'd4, 32'd7, 32'd0, 0, 10, 32'h11, 32'h22);

    // signed overflow case
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 10, 32'h0, 32'h8000_0000);

    // mthi while idle
    MDOp = 3'd5; A = 32'h1234_5678;
    tick();
    MDOp = 3'd0;
    check("mthi_idle_hi", HI, 32'h1234_5678);
    check("mthi_idle_busy", {31'd0, Busy}, 32'd0);

    // mtlo during RUN is ignored
    MDOp = 3'd1; A = 32'd3; B = 32'd4;
    tick();
    MDOp = 3'd6; A = 32'hDEAD_BEEF;
    tick();
    tick();
    check("mtlo_run_lo", LO, 32'h8000_0000);
    check("mtlo_run_hi", HI, 32'h1234_5678);
    MDOp = 3'd0;
    n = 2;
    while (Busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("mult34_cycles", n, 32'd5);
    check("mult34_hi", HI, 32'd0);
    check("mult34_lo", LO, 32'd12);

    // operands zeroed and div requested during RUN
    run_op("mult67", 3'd1, 32'd6, 32'd7, 2, 5, 32'd0, 32'd42);

    // reset mid-operation
    MDOp = 3'd1; A = 32'd9; B = 32'd9;
    tick();
    MDOp = 3'd0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, Busy}, 32'd0);
    check("rst_mid_hi", HI, 32'd0);
    check("rst_mid_lo", LO, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    repeat (8) tick();
    check("rst_nocommit_busy", {31'd0, Busy}, 32'd0);
    check("rst_nocommit_hi", HI, 32'd0);
    check("rst_nocommit_lo", LO, 32'd0);

    // Start taken on first edge after release
    reset = 1'b1;
    MDOp = 3'd1; A = 32'd2; B = 32'd3;
    #2 reset = 1'b0;
    run_op("post_rst", 3'd1, 32'd2, 32'd3, 0, 5, 32'd0, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
